// File: rtl/imem_arbiter_if.sv
// Bundle of fetch, loader and memory-side signals around the instruction memory arbiter.
// The arbiter uses the slave view; requesters and the memory array use the master view.
interface imem_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [31:0]       fetch_rdata;
  logic              fetch_err;

  logic              ld_valid;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_wdata;
  logic              ld_ready;
  logic              ld_err;
  logic              ld_done;
  logic              boot_busy;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, ld_valid, ld_addr, ld_wdata, ld_done, mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
           ld_ready, ld_err, boot_busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, ld_valid, ld_addr, ld_wdata, ld_done, mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
           ld_ready, ld_err, boot_busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the single instruction-memory port between the IF fetch port and the program loader.
// A boot phase serves only the loader; in run mode fetch has priority, bounded by a streak counter.
module imem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int MAX_STREAK = 8,
  parameter bit BOOT_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  imem_arbiter_if.slave      bus
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  localparam state_t RESET_STATE = BOOT_EN ? BOOT : RUN;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          rvalid_q;
  logic          rerr_q;
  logic [31:0]   rdataHold_q;

  logic              fetchWin, ldWin;
  logic              fetchInRange, ldInRange;
  logic [ADDR_W-1:0] fetchIdx, ldIdx;
  logic              unusedAddrBits;

  assign fetchIdx       = bus.fetch_addr[ADDR_W+1:2];
  assign ldIdx          = bus.ld_addr[ADDR_W+1:2];
  assign fetchInRange   = (bus.fetch_addr[31:ADDR_W+2] == '0);
  assign ldInRange      = (bus.ld_addr[31:ADDR_W+2] == '0);
  assign unusedAddrBits = ^{bus.fetch_addr[1:0], bus.ld_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      streak_q    <= '0;
      rvalid_q    <= 1'b0;
      rerr_q      <= 1'b0;
      rdataHold_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      rvalid_q <= fetchWin;
      rerr_q   <= fetchWin && !fetchInRange;
      if (rvalid_q) begin
        rdataHold_q <= rerr_q ? 32'h0 : bus.mem_rdata;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    fetchWin = 1'b0;
    ldWin    = 1'b0;
    case (state_q)
      BOOT: begin
        ldWin = bus.ld_valid;
        if (bus.ld_done) begin
          state_d = RUN;
        end
      end
      RUN: begin
        ldWin    = bus.ld_valid && (!bus.fetch_req || streak_q == STREAK_MAX);
        fetchWin = bus.fetch_req && !ldWin;
      end
      default: state_d = RESET_STATE;
    endcase

    streak_d = streak_q;
    if (!bus.ld_valid || ldWin) begin
      streak_d = '0;
    end else if (fetchWin && streak_q != STREAK_MAX) begin
      streak_d = streak_q + SW'(1);
    end
  end

  // Memory port steering; out-of-range accesses are acknowledged but never reach the array.
  always_comb begin
    bus.fetch_gnt = fetchWin;
    bus.ld_ready  = ldWin;
    bus.ld_err    = ldWin && !ldInRange;
    bus.boot_busy = (state_q == BOOT);
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (ldWin && ldInRange) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = ldIdx;
      bus.mem_wdata = bus.ld_wdata;
    end else if (fetchWin && fetchInRange) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = fetchIdx;
    end
  end

  assign bus.fetch_rvalid = rvalid_q;
  assign bus.fetch_err    = rvalid_q && rerr_q;
  assign bus.fetch_rdata  = rvalid_q ? (rerr_q ? 32'h0 : bus.mem_rdata) : rdataHold_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: one instance booting through the loader, one starting in run mode.
// Each instance sits on its own interface with a small synchronous-read memory model.
module tb_imem_arbiter;

  localparam int ADDR_W = 10;

  logic clk;
  logic rstA;
  logic rstB;

  int checks = 0;
  int errors = 0;

  imem_arbiter_if #(.ADDR_W(ADDR_W)) busA ();
  imem_arbiter_if #(.ADDR_W(ADDR_W)) busB ();

  imem_arbiter #(.ADDR_W(ADDR_W), .MAX_STREAK(8), .BOOT_EN(1'b1)) dutA (
    .clk (clk),
    .rst (rstA),
    .bus (busA.slave)
  );

  imem_arbiter #(.ADDR_W(ADDR_W), .MAX_STREAK(8), .BOOT_EN(1'b0)) dutB (
    .clk (clk),
    .rst (rstB),
    .bus (busB.slave)
  );

  logic [31:0] memA [0:(1<<ADDR_W)-1];
  logic [31:0] memB [0:(1<<ADDR_W)-1];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      memA[i] = 32'h0;
      memB[i] = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (busA.mem_en) begin
      if (busA.mem_we) memA[busA.mem_addr] <= busA.mem_wdata;
      else             busA.mem_rdata      <= memA[busA.mem_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (busB.mem_en) begin
      if (busB.mem_we) memB[busB.mem_addr] <= busB.mem_wdata;
      else             busB.mem_rdata      <= memB[busB.mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkWord(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rstA = 1'b1;
    rstB = 1'b1;
    busA.fetch_req = 1'b0; busA.fetch_addr = '0;
    busA.ld_valid = 1'b0; busA.ld_addr = '0; busA.ld_wdata = '0; busA.ld_done = 1'b0;
    busB.fetch_req = 1'b0; busB.fetch_addr = '0;
    busB.ld_valid = 1'b0; busB.ld_addr = '0; busB.ld_wdata = '0; busB.ld_done = 1'b0;

    // Reset values
    sample();
    checkBit("rst.boot_busy", busA.boot_busy, 1'b1);
    checkBit("rst.fetch_gnt", busA.fetch_gnt, 1'b0);
    checkBit("rst.rvalid", busA.fetch_rvalid, 1'b0);
    checkWord("rst.rdata", busA.fetch_rdata, 32'h0);
    checkBit("rst.mem_en", busA.mem_en, 1'b0);
    checkBit("rst.ld_ready", busA.ld_ready, 1'b0);
    checkBit("rstB.boot_busy", busB.boot_busy, 1'b0);
    tick();
    rstA = 1'b0;

    // Boot: loader write with fetch held off
    busA.fetch_req = 1'b1; busA.fetch_addr = 32'h0;
    busA.ld_valid = 1'b1; busA.ld_addr = 32'h0; busA.ld_wdata = 32'h0062E233;
    sample();
    checkBit("boot.fetch_gnt", busA.fetch_gnt, 1'b0);
    checkBit("boot.ld_ready", busA.ld_ready, 1'b1);
    checkBit("boot.ld_err", busA.ld_err, 1'b0);
    checkBit("boot.mem_en", busA.mem_en, 1'b1);
    checkBit("boot.mem_we", busA.mem_we, 1'b1);
    checkWord("boot.mem_addr", 32'(busA.mem_addr), 32'h0);
    checkWord("boot.mem_wdata", busA.mem_wdata, 32'h0062E233);
    tick();
    busA.ld_valid = 1'b0; busA.ld_done = 1'b1;
    sample();
    checkBit("done.fetch_gnt", busA.fetch_gnt, 1'b0);
    checkBit("done.boot_busy", busA.boot_busy, 1'b1);
    checkBit("done.mem_en", busA.mem_en, 1'b0);
    tick();
    busA.ld_done = 1'b0;
    sample();
    checkBit("run.boot_busy", busA.boot_busy, 1'b0);
    checkBit("run.fetch_gnt", busA.fetch_gnt, 1'b1);
    checkBit("run.mem_en", busA.mem_en, 1'b1);
    checkBit("run.mem_we", busA.mem_we, 1'b0);
    checkWord("run.mem_addr", 32'(busA.mem_addr), 32'h0);
    tick();
    busA.fetch_req = 1'b0;
    sample();
    checkBit("fetch0.rvalid", busA.fetch_rvalid, 1'b1);
    checkWord("fetch0.rdata", busA.fetch_rdata, 32'h0062E233);
    checkBit("fetch0.err", busA.fetch_err, 1'b0);
    tick();
    sample();
    checkBit("hold.rvalid", busA.fetch_rvalid, 1'b0);
    checkWord("hold.rdata", busA.fetch_rdata, 32'h0062E233);
    tick();

    // Streak: 8 fetch grants then one loader grant, repeated; ld_done ignored in RUN
    busA.fetch_req = 1'b1; busA.fetch_addr = 32'h8;
    busA.ld_valid = 1'b1; busA.ld_addr = 32'h10; busA.ld_wdata = 32'h11112222; busA.ld_done = 1'b1;
    for (int i = 0; i < 18; i++) begin
      sample();
      checkBit($sformatf("streak%0d.fetch_gnt", i), busA.fetch_gnt, (i % 9) != 8);
      checkBit($sformatf("streak%0d.ld_ready", i), busA.ld_ready, (i % 9) == 8);
      checkBit($sformatf("streak%0d.boot_busy", i), busA.boot_busy, 1'b0);
      tick();
    end
    busA.fetch_req = 1'b0; busA.ld_valid = 1'b0; busA.ld_done = 1'b0;
    sample();
    checkBit("idle.mem_en", busA.mem_en, 1'b0);
    checkWord("idle.mem_addr", 32'(busA.mem_addr), 32'h0);
    checkWord("idle.mem_wdata", busA.mem_wdata, 32'h0);
    checkBit("idle.rvalid", busA.fetch_rvalid, 1'b0);
    tick();

    // Out-of-range fetch
    busA.fetch_req = 1'b1; busA.fetch_addr = 32'h00001000;
    sample();
    checkBit("oorf.fetch_gnt", busA.fetch_gnt, 1'b1);
    checkBit("oorf.mem_en", busA.mem_en, 1'b0);
    tick();
    busA.fetch_req = 1'b0;
    sample();
    checkBit("oorf.rvalid", busA.fetch_rvalid, 1'b1);
    checkBit("oorf.err", busA.fetch_err, 1'b1);
    checkWord("oorf.rdata", busA.fetch_rdata, 32'h0);
    checkBit("oorf.mem_en2", busA.mem_en, 1'b0);
    tick();
    sample();
    checkBit("oorf.rvalid_end", busA.fetch_rvalid, 1'b0);
    checkBit("oorf.err_end", busA.fetch_err, 1'b0);
    tick();

    // Out-of-range loader write
    busA.ld_valid = 1'b1; busA.ld_addr = 32'h00002000; busA.ld_wdata = 32'hDEADBEEF;
    sample();
    checkBit("oorl.ld_ready", busA.ld_ready, 1'b1);
    checkBit("oorl.ld_err", busA.ld_err, 1'b1);
    checkBit("oorl.mem_we", busA.mem_we, 1'b0);
    checkBit("oorl.mem_en", busA.mem_en, 1'b0);
    tick();
    busA.ld_valid = 1'b0;
    sample();
    checkBit("oorl.ld_err_end", busA.ld_err, 1'b0);
    checkBit("oorl.ld_ready_end", busA.ld_ready, 1'b0);
    tick();

    // Reset between a fetch grant and its rvalid
    busA.fetch_req = 1'b1; busA.fetch_addr = 32'h0;
    sample();
    checkBit("rstmid.gnt1", busA.fetch_gnt, 1'b1);
    tick();
    sample();
    checkBit("rstmid.rvalid1", busA.fetch_rvalid, 1'b1);
    checkWord("rstmid.rdata1", busA.fetch_rdata, 32'h0062E233);
    checkBit("rstmid.gnt2", busA.fetch_gnt, 1'b1);
    tick();
    rstA = 1'b1; busA.fetch_req = 1'b0;
    #1;
    checkBit("rstmid.rvalid_cut", busA.fetch_rvalid, 1'b0);
    checkWord("rstmid.rdata_rst", busA.fetch_rdata, 32'h0);
    checkBit("rstmid.err_rst", busA.fetch_err, 1'b0);
    checkBit("rstmid.boot_busy", busA.boot_busy, 1'b1);
    tick();
    rstA = 1'b0; busA.fetch_req = 1'b1;
    sample();
    checkBit("rstmid.rvalid_after", busA.fetch_rvalid, 1'b0);
    checkBit("rstmid.boot_after", busA.boot_busy, 1'b1);
    checkBit("rstmid.gnt_boot", busA.fetch_gnt, 1'b0);
    tick();
    busA.fetch_req = 1'b0;

    // BOOT_EN=0 instance: immediate fetch service, write-then-read
    rstB = 1'b0;
    busB.fetch_req = 1'b1; busB.fetch_addr = 32'h0;
    sample();
    checkBit("b.first_gnt", busB.fetch_gnt, 1'b1);
    checkBit("b.boot_busy0", busB.boot_busy, 1'b0);
    tick();
    busB.fetch_req = 1'b0;
    busB.ld_valid = 1'b1; busB.ld_addr = 32'h4; busB.ld_wdata = 32'hCAFEF00D;
    sample();
    checkBit("b.ld_ready", busB.ld_ready, 1'b1);
    checkBit("b.mem_we", busB.mem_we, 1'b1);
    checkWord("b.wr_addr", 32'(busB.mem_addr), 32'h1);
    checkBit("b.boot_busy1", busB.boot_busy, 1'b0);
    tick();
    busB.ld_valid = 1'b0;
    busB.fetch_req = 1'b1; busB.fetch_addr = 32'h6;
    sample();
    checkBit("b.rd_gnt", busB.fetch_gnt, 1'b1);
    checkWord("b.rd_addr", 32'(busB.mem_addr), 32'h1);
    tick();
    busB.fetch_req = 1'b0;
    sample();
    checkBit("b.rvalid", busB.fetch_rvalid, 1'b1);
    checkWord("b.rdata", busB.fetch_rdata, 32'hCAFEF00D);
    checkBit("b.err", busB.fetch_err, 1'b0);
    checkBit("b.boot_busy2", busB.boot_busy, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
